// File: rtl/hash_drbg_pkg.sv
// hash_drbg_pkg: shared widths, padding constants and FSM encoding for the Hash_DRBG generator
package hash_drbg_pkg;
  localparam int SEEDLEN = 440;
  localparam int OUT_WIDTH = 256;
  localparam int BLOCK_WIDTH = 512;
  localparam logic [63:0] LEN_V = 64'd440;
  localparam logic [63:0] LEN_W = 64'd448;
  localparam logic [7:0] DOMAIN_BYTE = 8'h03;
  localparam logic [7:0] PAD_BYTE = 8'h80;
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HASH_V = 3'd1,
    EMIT = 3'd2,
    HASH_W0 = 3'd3,
    HASH_W1 = 3'd4,
    UPDATE = 3'd5
  } state_t;
endpackage

// File: rtl/hash_drbg_generator_sha256.sv
// sha256_core: one SHA-256 compression per start, one round per clock, optional chaining
module sha256_core
  import hash_drbg_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   init,
  input  logic [BLOCK_WIDTH-1:0] block,
  output logic                   done,
  output logic [OUT_WIDTH-1:0]   digest
);
  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  localparam logic [31:0] IV [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a, 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };
  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  logic [31:0] hv [8];
  logic [31:0] st [8];
  logic [31:0] ns [8];
  logic [31:0] w [16];
  logic [31:0] t1, t2, w_new;
  logic [5:0] round;
  logic run;
  assign digest = {hv[0], hv[1], hv[2], hv[3], hv[4], hv[5], hv[6], hv[7]};
  always_comb begin
    t1 = st[7] + (rotr(st[4], 6) ^ rotr(st[4], 11) ^ rotr(st[4], 25)) + ((st[4] & st[5]) ^ (~st[4] & st[6])) + K[round] + w[0];
    t2 = (rotr(st[0], 2) ^ rotr(st[0], 13) ^ rotr(st[0], 22)) + ((st[0] & st[1]) ^ (st[0] & st[2]) ^ (st[1] & st[2]));
    w_new = (rotr(w[14], 17) ^ rotr(w[14], 19) ^ (w[14] >> 10)) + w[9] + (rotr(w[1], 7) ^ rotr(w[1], 18) ^ (w[1] >> 3)) + w[0];
    ns[0] = t1 + t2;
    ns[1] = st[0];
    ns[2] = st[1];
    ns[3] = st[2];
    ns[4] = st[3] + t1;
    ns[5] = st[4];
    ns[6] = st[5];
    ns[7] = st[6];
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) begin
        hv[i] <= '0;
        st[i] <= '0;
      end
      for (int i = 0; i < 16; i++) w[i] <= '0;
      round <= '0;
      run <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        for (int i = 0; i < 8; i++) begin
          if (init) hv[i] <= IV[i];
          st[i] <= init ? IV[i] : hv[i];
        end
        for (int i = 0; i < 16; i++) w[i] <= block[BLOCK_WIDTH-1-32*i -: 32];
        round <= '0;
        run <= 1'b1;
      end else if (run) begin
        for (int i = 0; i < 8; i++) st[i] <= ns[i];
        for (int i = 0; i < 15; i++) w[i] <= w[i+1];
        w[15] <= w_new;
        round <= round + 1'b1;
        if (&round) begin
          run <= 1'b0;
          done <= 1'b1;
          for (int i = 0; i < 8; i++) hv[i] <= hv[i] + ns[i];
        end
      end
    end
  end
endmodule

// File: rtl/hash_drbg_generator.sv
// hash_drbg_generator: Hash_DRBG generate over SHA-256, one 256-bit keystream block per request
module hash_drbg_generator
  import hash_drbg_pkg::*;
#(
  parameter int CNT_WIDTH = 32,
  parameter logic [CNT_WIDTH-1:0] RESEED_LIMIT = CNT_WIDTH'(2**24)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [SEEDLEN-1:0]   seed_v,
  input  logic [SEEDLEN-1:0]   seed_c,
  input  logic                 seed_load,
  input  logic                 need_next,
  output logic [OUT_WIDTH-1:0] data_out,
  output logic                 data_out_valid,
  output logic                 generator_busy,
  output logic                 seeded,
  output logic                 reseed_required
);
  state_t state, next;
  logic start, init, core_done, adv;
  logic [OUT_WIDTH-1:0] digest;
  logic [BLOCK_WIDTH-1:0] block;
  logic [SEEDLEN-1:0] v, c;
  logic [CNT_WIDTH-1:0] cnt, cnt_next;
  assign adv = core_done && !start;
  assign cnt_next = &cnt ? cnt : cnt + 1'b1;
  sha256_core u_core (
    .clk(clk),
    .reset(reset),
    .start(start),
    .init(init),
    .block(block),
    .done(core_done),
    .digest(digest)
  );
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      start <= 1'b0;
    end else begin
      state <= next;
      start <= next != state && (next == HASH_V || next == HASH_W0 || next == HASH_W1);
    end
  end
  always_comb begin
    next = state;
    case (state)
      IDLE: next = need_next && seeded ? HASH_V : IDLE;
      HASH_V: next = adv ? EMIT : HASH_V;
      EMIT: next = HASH_W0;
      HASH_W0: next = adv ? HASH_W1 : HASH_W0;
      HASH_W1: next = adv ? UPDATE : HASH_W1;
      UPDATE: next = IDLE;
      default: next = IDLE;
    endcase
    if (seed_load) next = IDLE;
  end
  always_comb begin
    generator_busy = state != IDLE;
    data_out_valid = state == EMIT;
    init = state != HASH_W1;
    block = state == HASH_V ? {v, PAD_BYTE, LEN_V}
          : state == HASH_W0 ? {DOMAIN_BYTE, v, PAD_BYTE, 56'd0}
          : {448'd0, LEN_W};
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v <= '0;
      c <= '0;
      cnt <= '0;
      data_out <= '0;
      seeded <= 1'b0;
      reseed_required <= 1'b0;
    end else if (seed_load) begin
      v <= seed_v;
      c <= seed_c;
      cnt <= CNT_WIDTH'(1);
      seeded <= 1'b1;
      reseed_required <= 1'b0;
    end else begin
      if (state == HASH_V && adv) data_out <= digest;
      if (state == UPDATE) begin
        v <= v + SEEDLEN'(digest) + c + SEEDLEN'(cnt);
        cnt <= cnt_next;
        reseed_required <= reseed_required || cnt_next > RESEED_LIMIT;
      end
    end
  end
endmodule

// File: tb/tb_hash_drbg_generator.sv
// tb_hash_drbg_generator: randomized directed bench against a byte-level SHA-256/Hash_DRBG model
module tb_hash_drbg_generator;
  import hash_drbg_pkg::*;
  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  localparam logic [31:0] HT [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a, 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [439:0] seed_v = '0, seed_c = '0;
  logic seed_load = 1'b0, need_next = 1'b0, seed_load2 = 1'b0, need_next2 = 1'b0;
  logic [255:0] data_out, data_out2;
  logic data_out_valid, generator_busy, seeded, reseed_required;
  logic data_out_valid2, generator_busy2, seeded2, reseed_required2;
  int vectors = 0, errors = 0, vcnt = 0, scnt = 0;
  logic [439:0] mv [2];
  logic [439:0] mc [2];
  logic [31:0] mcnt [2];
  always #5 clk = ~clk;
  hash_drbg_generator dut (
    .clk(clk), .reset(reset), .seed_v(seed_v), .seed_c(seed_c), .seed_load(seed_load), .need_next(need_next),
    .data_out(data_out), .data_out_valid(data_out_valid), .generator_busy(generator_busy),
    .seeded(seeded), .reseed_required(reseed_required)
  );
  hash_drbg_generator #(.RESEED_LIMIT(32'd2)) dut2 (
    .clk(clk), .reset(reset), .seed_v(seed_v), .seed_c(seed_c), .seed_load(seed_load2), .need_next(need_next2),
    .data_out(data_out2), .data_out_valid(data_out_valid2), .generator_busy(generator_busy2),
    .seeded(seeded2), .reseed_required(reseed_required2)
  );
  always @(posedge clk) begin
    if (data_out_valid) vcnt++;
    if (dut.start) scnt++;
  end
  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic logic [255:0] sha256(input byte unsigned m[$]);
    byte unsigned p[$];
    logic [63:0] bits;
    logic [31:0] h [8];
    logic [31:0] w [64];
    logic [31:0] a, b, c2, d, e, f, g, hh, t1, t2;
    p = m;
    bits = 64'(m.size()) * 64'd8;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    for (int i = 7; i >= 0; i--) p.push_back(bits[8*i +: 8]);
    for (int i = 0; i < 8; i++) h[i] = HT[i];
    for (int o = 0; o < p.size(); o += 64) begin
      for (int t = 0; t < 16; t++) w[t] = {p[o+4*t], p[o+4*t+1], p[o+4*t+2], p[o+4*t+3]};
      for (int t = 16; t < 64; t++)
        w[t] = (ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
             + (ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
      a = h[0]; b = h[1]; c2 = h[2]; d = h[3]; e = h[4]; f = h[5]; g = h[6]; hh = h[7];
      for (int t = 0; t < 64; t++) begin
        t1 = hh + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + KT[t] + w[t];
        t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c2) ^ (b & c2));
        hh = g; g = f; f = e; e = d + t1; d = c2; c2 = b; b = a; a = t1 + t2;
      end
      h[0] += a; h[1] += b; h[2] += c2; h[3] += d; h[4] += e; h[5] += f; h[6] += g; h[7] += hh;
    end
    return {h[0], h[1], h[2], h[3], h[4], h[5], h[6], h[7]};
  endfunction
  function automatic logic [255:0] hash_v(input logic [439:0] v, input bit dom);
    byte unsigned m[$];
    if (dom) m.push_back(8'h03);
    for (int i = 0; i < 55; i++) m.push_back(v[439-8*i -: 8]);
    return sha256(m);
  endfunction
  function automatic logic [439:0] rnd440();
    logic [447:0] t;
    for (int i = 0; i < 14; i++) t[32*i +: 32] = $urandom;
    return t[439:0];
  endfunction
  function automatic logic busy_of(input int d);
    return d != 0 ? generator_busy2 : generator_busy;
  endfunction
  function automatic logic valid_of(input int d);
    return d != 0 ? data_out_valid2 : data_out_valid;
  endfunction
  function automatic logic [255:0] out_of(input int d);
    return d != 0 ? data_out2 : data_out;
  endfunction
  function automatic logic [439:0] v_of(input int d);
    return d != 0 ? dut2.v : dut.v;
  endfunction
  function automatic logic [31:0] cnt_of(input int d);
    return d != 0 ? dut2.cnt : dut.cnt;
  endfunction
  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask
  task automatic set_nn(input int d, input logic x);
    if (d != 0) need_next2 = x;
    else need_next = x;
  endtask
  task automatic load(input int d, input logic [439:0] v, input logic [439:0] c);
    @(negedge clk);
    seed_v = v;
    seed_c = c;
    if (d != 0) seed_load2 = 1'b1;
    else seed_load = 1'b1;
    @(negedge clk);
    seed_load = 1'b0;
    seed_load2 = 1'b0;
    mv[d] = v;
    mc[d] = c;
    mcnt[d] = 32'd1;
  endtask
  task automatic wait_valid(input int d, input string tag);
    int k;
    k = 0;
    while (!valid_of(d) && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_latency"}, 512'(k), 512'd66);
  endtask
  task automatic wait_idle(input int d, input string tag);
    int k;
    k = 0;
    while (busy_of(d) && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_idle"}, 512'(busy_of(d)), 512'd0);
  endtask
  task automatic req(input int d, input string tag);
    logic [255:0] e;
    e = hash_v(mv[d], 1'b0);
    mv[d] = mv[d] + 440'(hash_v(mv[d], 1'b1)) + mc[d] + 440'(mcnt[d]);
    mcnt[d] = mcnt[d] + 32'd1;
    @(negedge clk);
    set_nn(d, 1'b1);
    @(negedge clk);
    set_nn(d, 1'b0);
    chk({tag, "_busy_rise"}, 512'(busy_of(d)), 512'd1);
    wait_valid(d, tag);
    chk({tag, "_data"}, 512'(out_of(d)), 512'(e));
    wait_idle(d, tag);
    chk({tag, "_v"}, 512'(v_of(d)), 512'(mv[d]));
    chk({tag, "_cnt"}, 512'(cnt_of(d)), 512'(mcnt[d]));
  endtask
  initial begin
    logic [255:0] e;
    logic [439:0] nv, nc;
    byte unsigned abc[$];
    int k, v0, s0;
    abc = '{8'h61, 8'h62, 8'h63};
    if (sha256(abc) !== 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad) begin
      $display("FAIL model_selftest sha256(abc) wrong");
      $fatal(1);
    end
    repeat (3) @(negedge clk);
    chk("rst_data", 512'(data_out), 512'd0);
    chk("rst_valid", 512'(data_out_valid), 512'd0);
    chk("rst_busy", 512'(generator_busy), 512'd0);
    chk("rst_seeded", 512'(seeded), 512'd0);
    chk("rst_reseed", 512'(reseed_required), 512'd0);
    reset = 1'b0;
    @(negedge clk);
    need_next = 1'b1;
    @(negedge clk);
    need_next = 1'b0;
    chk("unseeded_busy", 512'(generator_busy), 512'd0);
    repeat (3) @(negedge clk);
    chk("unseeded_valid", 512'(vcnt), 512'd0);
    load(0, '0, '0);
    chk("zero_seeded", 512'(seeded), 512'd1);
    chk("zero_cnt", 512'(dut.cnt), 512'd1);
    req(0, "zero");
    chk("zero_v_formula", 512'(dut.v), 512'(440'(hash_v('0, 1'b1)) + 440'd1));
    chk("zero_one_valid", 512'(vcnt), 512'd1);
    load(0, rnd440(), rnd440());
    for (int i = 0; i < 3; i++) begin
      req(0, $sformatf("rand%0d", i));
      repeat (8) @(negedge clk);
    end
    chk("rand_cnt4", 512'(dut.cnt), 512'd4);
    v0 = vcnt;
    s0 = scnt;
    e = hash_v(mv[0], 1'b0);
    mv[0] = mv[0] + 440'(hash_v(mv[0], 1'b1)) + mc[0] + 440'(mcnt[0]);
    mcnt[0] = mcnt[0] + 32'd1;
    @(negedge clk);
    need_next = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
      need_next = generator_busy;
    end while (generator_busy && k < 500);
    need_next = 1'b0;
    chk("hammer_idle", 512'(generator_busy), 512'd0);
    repeat (2) @(negedge clk);
    chk("hammer_data", 512'(data_out), 512'(e));
    chk("hammer_one_valid", 512'(vcnt - v0), 512'd1);
    chk("hammer_starts", 512'(scnt - s0), 512'd3);
    chk("hammer_v", 512'(dut.v), 512'(mv[0]));
    v0 = vcnt;
    e = hash_v(mv[0], 1'b0);
    @(negedge clk);
    need_next = 1'b1;
    @(negedge clk);
    need_next = 1'b0;
    wait_valid(0, "abort");
    chk("abort_data", 512'(data_out), 512'(e));
    repeat (5) @(negedge clk);
    nv = rnd440();
    nc = rnd440();
    load(0, nv, nc);
    chk("abort_busy", 512'(generator_busy), 512'd0);
    chk("abort_v", 512'(dut.v), 512'(nv));
    chk("abort_c", 512'(dut.c), 512'(nc));
    chk("abort_cnt", 512'(dut.cnt), 512'd1);
    chk("abort_one_valid", 512'(vcnt - v0), 512'd1);
    req(0, "post_abort");
    @(negedge clk);
    need_next = 1'b1;
    @(negedge clk);
    need_next = 1'b0;
    wait_valid(0, "w0rst");
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("w0rst_data", 512'(data_out), 512'd0);
    chk("w0rst_valid", 512'(data_out_valid), 512'd0);
    chk("w0rst_busy", 512'(generator_busy), 512'd0);
    chk("w0rst_seeded", 512'(seeded), 512'd0);
    chk("w0rst_reseed", 512'(reseed_required), 512'd0);
    chk("w0rst_state", 512'(dut.state), 512'(IDLE));
    @(negedge clk);
    reset = 1'b0;
    v0 = vcnt;
    @(negedge clk);
    need_next = 1'b1;
    @(negedge clk);
    need_next = 1'b0;
    chk("w0rst_ignored_busy", 512'(generator_busy), 512'd0);
    repeat (4) @(negedge clk);
    chk("w0rst_ignored_valid", 512'(vcnt - v0), 512'd0);
    load(1, rnd440(), rnd440());
    req(1, "rs1");
    chk("rs1_flag", 512'(reseed_required2), 512'd0);
    req(1, "rs2");
    chk("rs2_flag", 512'(reseed_required2), 512'd1);
    req(1, "rs3");
    req(1, "rs4");
    chk("rs4_flag", 512'(reseed_required2), 512'd1);
    load(1, rnd440(), rnd440());
    chk("rs_cleared", 512'(reseed_required2), 512'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
